// File: rtl/genesis_pad_reader.sv
// Sega Genesis / Mega Drive DB9 pad reader: drives select, runs the 6-button
// scan once per poll frame, debounces across two frames and emits press pulses.
module genesis_pad_reader #(
  parameter int unsigned PHASE_CYCLES = 500,
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic        clock_50,
  input  logic        reset_key,
  input  logic        pad_up_n,
  input  logic        pad_down_n,
  input  logic        pad_left_n,
  input  logic        pad_right_n,
  input  logic        pad_ab_n,
  input  logic        pad_cs_n,
  output logic        pad_select,
  output logic [11:0] control_inputs,
  output logic [11:0] buttons_held,
  output logic        pad_connected,
  output logic        six_button
);

  localparam int unsigned PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_PH4,
    ST_PH5,
    ST_PH6,
    ST_PH7
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    pin_low;
  logic          frame_tick;
  logic          phase_done;

  logic          smp_ph0, smp_ph1, smp_ph5, smp_ph6, commit;

  logic [11:0]   raw_q, raw_d;
  logic [11:0]   prev_raw_q, prev_raw_d;
  logic [11:0]   held_q, held_d;
  logic [11:0]   pulse_q, pulse_d;
  logic [11:0]   frame_raw;
  logic          present_q, present_d;
  logic          six_raw_q, six_raw_d;
  logic          connected_q, connected_d;
  logic          six_button_q, six_button_d;

  // Pin order: [0] up, [1] down, [2] left, [3] right, [4] A/B, [5] Start/C.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {pad_cs_n, pad_ab_n, pad_right_n, pad_left_n, pad_down_n, pad_up_n};
      sync2_q <= sync1_q;
    end
  end

  assign pin_low = ~sync2_q;

  assign frame_tick = (frame_cnt_q == FRAME_LAST);
  assign phase_done = (phase_cnt_q == PHASE_LAST);

  always_comb begin
    frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;
    if (state_q == ST_IDLE) begin
      phase_cnt_d = '0;
    end else begin
      phase_cnt_d = phase_done ? '0 : phase_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      frame_cnt_q <= '0;
      phase_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ticks arriving mid-scan are simply ignored; the frame counter keeps running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_tick) state_d = ST_PH0;
      ST_PH0:  if (phase_done) state_d = ST_PH1;
      ST_PH1:  if (phase_done) state_d = ST_PH2;
      ST_PH2:  if (phase_done) state_d = ST_PH3;
      ST_PH3:  if (phase_done) state_d = ST_PH4;
      ST_PH4:  if (phase_done) state_d = ST_PH5;
      ST_PH5:  if (phase_done) state_d = ST_PH6;
      ST_PH6:  if (phase_done) state_d = ST_PH7;
      ST_PH7:  if (phase_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pad_select = 1'b1;
    smp_ph0    = 1'b0;
    smp_ph1    = 1'b0;
    smp_ph5    = 1'b0;
    smp_ph6    = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_PH0: smp_ph0 = phase_done;
      ST_PH1: begin
        pad_select = 1'b0;
        smp_ph1    = phase_done;
      end
      ST_PH3: pad_select = 1'b0;
      ST_PH5: begin
        pad_select = 1'b0;
        smp_ph5    = phase_done;
      end
      ST_PH6: smp_ph6 = phase_done;
      ST_PH7: begin
        pad_select = 1'b0;
        commit     = phase_done;
      end
      default: pad_select = 1'b1;
    endcase
  end

  always_comb begin
    raw_d        = raw_q;
    prev_raw_d   = prev_raw_q;
    held_d       = held_q;
    pulse_d      = '0;
    present_d    = present_q;
    six_raw_d    = six_raw_q;
    connected_d  = connected_q;
    six_button_d = six_button_q;
    frame_raw    = present_q ? raw_q : '0;

    if (smp_ph0) begin
      raw_d[0] = pin_low[0];
      raw_d[1] = pin_low[1];
      raw_d[2] = pin_low[2];
      raw_d[3] = pin_low[3];
      raw_d[5] = pin_low[4];
      raw_d[6] = pin_low[5];
    end
    if (smp_ph1) begin
      raw_d[4]  = pin_low[4];
      raw_d[10] = pin_low[5];
      present_d = pin_low[2] & pin_low[3];
    end
    if (smp_ph5) begin
      six_raw_d = &pin_low[3:0];
    end
    // A 3-button pad shows the d-pad again here, so extra buttons are masked.
    if (smp_ph6) begin
      raw_d[9]  = six_raw_q & pin_low[0];
      raw_d[8]  = six_raw_q & pin_low[1];
      raw_d[7]  = six_raw_q & pin_low[2];
      raw_d[11] = six_raw_q & pin_low[3];
    end
    if (commit) begin
      connected_d  = present_q;
      six_button_d = six_raw_q;
      prev_raw_d   = frame_raw;
      if (frame_raw == prev_raw_q) begin
        held_d = frame_raw;
      end
      pulse_d = held_d & ~held_q;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      raw_q        <= '0;
      prev_raw_q   <= '0;
      held_q       <= '0;
      pulse_q      <= '0;
      present_q    <= 1'b0;
      six_raw_q    <= 1'b0;
      connected_q  <= 1'b0;
      six_button_q <= 1'b0;
    end else begin
      raw_q        <= raw_d;
      prev_raw_q   <= prev_raw_d;
      held_q       <= held_d;
      pulse_q      <= pulse_d;
      present_q    <= present_d;
      six_raw_q    <= six_raw_d;
      connected_q  <= connected_d;
      six_button_q <= six_button_d;
    end
  end

  assign control_inputs = pulse_q;
  assign buttons_held   = held_q;
  assign pad_connected  = connected_q;
  assign six_button     = six_button_q;

endmodule

// File: tb/tb_genesis_pad_reader.sv
// Directed bench for genesis_pad_reader: behavioural 3/6-button pad model,
// per-frame vector table and hand-written reset / select-timing sequences.
module tb_genesis_pad_reader;

  localparam int NV = 25;

  typedef struct packed {
    logic [11:0] press;
    logic        plugged;
    logic        six_pad;
    logic [11:0] exp_pulse;
    logic [11:0] exp_held;
    logic        exp_conn;
    logic        exp_six;
  } vec_t;

  logic        clock_50 = 1'b0;
  logic        reset_key;
  logic        pad_up_n, pad_down_n, pad_left_n, pad_right_n, pad_ab_n, pad_cs_n;
  logic        pad_select;
  logic [11:0] control_inputs;
  logic [11:0] buttons_held;
  logic        pad_connected;
  logic        six_button;

  logic [11:0] press;
  logic        plugged;
  logic        six_pad;
  logic [5:0]  pins_n;
  int          low_idx = 0;
  int          hi_cnt = 0;
  logic        prev_sel = 1'b1;

  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs[NV];

  genesis_pad_reader #(
    .PHASE_CYCLES(4),
    .FRAME_CYCLES(64)
  ) dut (
    .clock_50      (clock_50),
    .reset_key     (reset_key),
    .pad_up_n      (pad_up_n),
    .pad_down_n    (pad_down_n),
    .pad_left_n    (pad_left_n),
    .pad_right_n   (pad_right_n),
    .pad_ab_n      (pad_ab_n),
    .pad_cs_n      (pad_cs_n),
    .pad_select    (pad_select),
    .control_inputs(control_inputs),
    .buttons_held  (buttons_held),
    .pad_connected (pad_connected),
    .six_button    (six_button)
  );

  always #5 clock_50 = ~clock_50;

  // Pad model tracks how many select-low pulses it has seen this scan.
  always @(negedge clock_50) begin
    if (!reset_key) begin
      low_idx = 0;
      hi_cnt  = 0;
    end else begin
      if (prev_sel && !pad_select) low_idx = low_idx + 1;
      if (pad_select) hi_cnt = hi_cnt + 1;
      else hi_cnt = 0;
      if (hi_cnt > 6) low_idx = 0;
    end
    prev_sel = pad_select;
  end

  // pins_n: [5] Start/C, [4] A/B, [3] right, [2] left, [1] down, [0] up
  always_comb begin
    pins_n = 6'h3F;
    if (plugged) begin
      if (pad_select) begin
        if (six_pad && low_idx == 3)
          pins_n = {~press[6], ~press[5], ~press[11], ~press[7], ~press[8], ~press[9]};
        else
          pins_n = {~press[6], ~press[5], ~press[3], ~press[2], ~press[1], ~press[0]};
      end else if (six_pad && low_idx == 3) begin
        pins_n = {~press[10], ~press[4], 4'b0000};
      end else begin
        pins_n = {~press[10], ~press[4], 2'b00, ~press[1], ~press[0]};
      end
    end
  end

  assign pad_up_n    = pins_n[0];
  assign pad_down_n  = pins_n[1];
  assign pad_left_n  = pins_n[2];
  assign pad_right_n = pins_n[3];
  assign pad_ab_n    = pins_n[4];
  assign pad_cs_n    = pins_n[5];

  function automatic vec_t mk(input logic [11:0] p, input logic pl, input logic sx,
                              input logic [11:0] ep, input logic [11:0] eh,
                              input logic ec, input logic es);
    vec_t v;
    v.press     = p;
    v.plugged   = pl;
    v.six_pad   = sx;
    v.exp_pulse = ep;
    v.exp_held  = eh;
    v.exp_conn  = ec;
    v.exp_six   = es;
    return v;
  endfunction

  function automatic logic exp_select(input int c);
    int p;
    if (c < 64) return 1'b1;
    p = (c - 64) % 64;
    if (p < 32) return ((p / 4) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    int quiet;
    int bad;
    int first_bad;

    // press, plugged, six_pad, exp_pulse, exp_held, exp_conn, exp_six
    vecs[0]  = mk(12'h000, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[1]  = mk(12'h400, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[2]  = mk(12'h400, 1, 0, 12'h400, 12'h400, 1, 0);
    vecs[3]  = mk(12'h400, 1, 0, 12'h000, 12'h400, 1, 0);
    vecs[4]  = mk(12'h000, 1, 0, 12'h000, 12'h400, 1, 0);
    vecs[5]  = mk(12'h000, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[6]  = mk(12'h010, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[7]  = mk(12'h000, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[8]  = mk(12'h010, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[9]  = mk(12'h010, 1, 0, 12'h010, 12'h010, 1, 0);
    vecs[10] = mk(12'h071, 1, 0, 12'h000, 12'h010, 1, 0);
    vecs[11] = mk(12'h071, 1, 0, 12'h061, 12'h071, 1, 0);
    vecs[12] = mk(12'hA00, 1, 1, 12'h000, 12'h071, 1, 1);
    vecs[13] = mk(12'hA00, 1, 1, 12'hA00, 12'hA00, 1, 1);
    vecs[14] = mk(12'hA00, 1, 1, 12'h000, 12'hA00, 1, 1);
    vecs[15] = mk(12'hA81, 1, 1, 12'h000, 12'hA00, 1, 1);
    vecs[16] = mk(12'hA81, 1, 1, 12'h081, 12'hA81, 1, 1);
    vecs[17] = mk(12'h009, 1, 0, 12'h000, 12'hA81, 1, 0);
    vecs[18] = mk(12'h009, 1, 0, 12'h008, 12'h009, 1, 0);
    vecs[19] = mk(12'h008, 1, 0, 12'h000, 12'h009, 1, 0);
    vecs[20] = mk(12'h008, 1, 0, 12'h000, 12'h008, 1, 0);
    vecs[21] = mk(12'h008, 0, 0, 12'h000, 12'h008, 0, 0);
    vecs[22] = mk(12'h008, 0, 0, 12'h000, 12'h000, 0, 0);
    vecs[23] = mk(12'h008, 1, 0, 12'h000, 12'h000, 1, 0);
    vecs[24] = mk(12'h008, 1, 0, 12'h008, 12'h008, 1, 0);

    reset_key = 1'b0;
    press     = '0;
    plugged   = 1'b1;
    six_pad   = 1'b0;
    repeat (3) @(posedge clock_50);
    #1;
    check("reset_select", {11'd0, pad_select}, 12'h001);
    check("reset_pulse", control_inputs, 12'h000);
    check("reset_held", buttons_held, 12'h000);
    check("reset_conn", {11'd0, pad_connected}, 12'h000);
    check("reset_six", {11'd0, six_button}, 12'h000);

    @(negedge clock_50);
    reset_key = 1'b1;

    // Commits land on edge 96 after release, then every 64 cycles.
    for (int i = 0; i < NV; i++) begin
      press   = vecs[i].press;
      plugged = vecs[i].plugged;
      six_pad = vecs[i].six_pad;
      quiet   = 0;
      repeat ((i == 0) ? 95 : 63) begin
        @(posedge clock_50);
        #1;
        if (control_inputs != 12'h000) quiet = quiet + 1;
      end
      check($sformatf("quiet_f%0d", i), 12'(quiet), 12'h000);
      @(posedge clock_50);
      #1;
      check($sformatf("pulse_f%0d", i), control_inputs, vecs[i].exp_pulse);
      check($sformatf("held_f%0d", i), buttons_held, vecs[i].exp_held);
      check($sformatf("conn_f%0d", i), {11'd0, pad_connected}, {11'd0, vecs[i].exp_conn});
      check($sformatf("six_f%0d", i), {11'd0, six_button}, {11'd0, vecs[i].exp_six});
    end
    @(posedge clock_50);
    #1;
    check("pulse_width", control_inputs, 12'h000);

    // Reset in the middle of PH3 with Right held and the pad connected.
    repeat (43) @(posedge clock_50);
    #1;
    check("ph3_select", {11'd0, pad_select}, 12'h000);
    #2;
    reset_key = 1'b0;
    #1;
    check("midscan_select", {11'd0, pad_select}, 12'h001);
    check("midscan_held", buttons_held, 12'h000);
    check("midscan_pulse", control_inputs, 12'h000);
    check("midscan_conn", {11'd0, pad_connected}, 12'h000);
    check("midscan_six", {11'd0, six_button}, 12'h000);
    repeat (2) @(posedge clock_50);
    #1;
    check("held_select", {11'd0, pad_select}, 12'h001);

    plugged = 1'b0;
    press   = '0;
    @(negedge clock_50);
    reset_key = 1'b1;
    bad       = 0;
    first_bad = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock_50);
      #1;
      if (pad_select !== exp_select(c)) begin
        bad = bad + 1;
        if (first_bad < 0) first_bad = c;
      end
      if (c == 96) begin
        check("nopad_conn", {11'd0, pad_connected}, 12'h000);
      end
    end
    if (bad != 0) $display("select timing first differs at cycle %0d", first_bad);
    check("select_timing", 12'(bad), 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
